// File: rtl/cfg_apb_master.sv
// ---------------------------------------------------------------------------
// cfg_apb_master
//
// APB3 requester that sits in front of the configuration register slave.
// Each accepted request becomes exactly one APB SETUP -> ACCESS transfer.
// The result (read data + error flag) is then offered on a response channel.
// Word-misaligned requests are rejected locally without touching the bus.
// A bounded ACCESS-phase timeout keeps a hung slave from stalling the
// config path.
//
// Handshake rule (both channels): a beat transfers on a rising clk edge
// where valid and ready are both high. The producer holds valid and its
// payload stable until that edge. The producer never withdraws valid
// without a transfer.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   req_valid_i     request valid
//   req_ready_o     request accepted when high together with req_valid_i
//   req_write_i     1 = write, 0 = read
//   req_addr_i      byte address (must be word aligned)
//   req_wdata_i     write data
//   rsp_valid_o     response valid
//   rsp_ready_i     response consumed
//   rsp_rdata_o     read data (0 for writes and errors)
//   rsp_err_o       pslverr, timeout or misaligned address
//   psel_o, penable_o, paddr_o, pwrite_o, pwdata_o   APB requester outputs
//   pready_i, prdata_i, pslverr_i                    APB completer inputs
//
// Parameters
//   ADDR_W   APB byte address width
//   DATA_W   data width
//   TIMEOUT  maximum ACCESS-phase cycles before abort; 0 disables it
// ---------------------------------------------------------------------------
module cfg_apb_master #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  // request channel
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  // response channel
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  // APB
  output logic              psel_o,
  output logic              penable_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic              pwrite_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic              pready_i,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pslverr_i
);

  // The wait counter only has to reach TIMEOUT-1, so it needs
  // clog2(TIMEOUT) bits. It is kept at least 1 bit wide so the
  // declaration stays legal when the timeout is disabled or trivial.
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  state_e              state_q,  state_d;
  logic [ADDR_W-1:0]   paddr_q,  paddr_d;
  logic                pwrite_q, pwrite_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [DATA_W-1:0]   rdata_q,  rdata_d;
  logic                err_q,    err_d;
  logic [CNT_W-1:0]    wait_q,   wait_d;

  // Abort condition: the slave has held pready low for the whole timeout window.
  logic timeout_hit;
  assign timeout_hit = (TIMEOUT != 0) && (wait_q == CNT_LAST) && !pready_i;

  // -------------------------------------------------------------------------
  // State and payload registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      wait_q   <= wait_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    wait_d   = wait_q;

    unique case (state_q)
      ST_IDLE: begin
        // req_ready_o is high throughout IDLE, so valid alone completes
        // the handshake here.
        wait_d = '0;
        if (req_valid_i) begin
          paddr_d  = req_addr_i;
          pwrite_d = req_write_i;
          pwdata_d = req_wdata_i;
          rdata_d  = '0;
          if (req_addr_i[1:0] == 2'b00) begin
            err_d   = 1'b0;
            state_d = ST_SETUP;
          end else begin
            // Misaligned: answer immediately with an error, no bus cycle.
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end

      ST_SETUP: begin
        wait_d  = '0;
        state_d = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (pready_i) begin
          // Completion wins over timeout, even in the last allowed cycle.
          rdata_d = pwrite_q ? '0 : prdata_i;
          err_d   = pslverr_i;
          wait_d  = '0;
          state_d = ST_RESP;
        end else if (timeout_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
          wait_d  = '0;
          state_d = ST_RESP;
        end else if (TIMEOUT != 0) begin
          wait_d = wait_q + CNT_W'(1);
        end
      end

      ST_RESP: begin
        wait_d = '0;
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs: decoded from state or taken straight from registers.
  // req_ready_o is additionally qualified by rst_n. IDLE is also the reset
  // state, and the requester must not look ready while reset is asserted.
  // -------------------------------------------------------------------------
  assign req_ready_o = (state_q == ST_IDLE) && rst_n;
  assign psel_o      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign penable_o   = (state_q == ST_ACCESS);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign paddr_o     = paddr_q;
  assign pwrite_o    = pwrite_q;
  assign pwdata_o    = pwdata_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_cfg_apb_master.sv
// ---------------------------------------------------------------------------
// tb_cfg_apb_master
//
// Directed bench for cfg_apb_master (TIMEOUT = 16).
// Inputs are driven and outputs are sampled on the falling clock edge.
// The DUT therefore sees stable inputs at every rising edge.
// ---------------------------------------------------------------------------
module tb_cfg_apb_master;

  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic              clk;
  logic              rst_n;
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_write_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [DATA_W-1:0] req_wdata_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DATA_W-1:0] rsp_rdata_o;
  logic              rsp_err_o;
  logic              psel_o;
  logic              penable_o;
  logic [ADDR_W-1:0] paddr_o;
  logic              pwrite_o;
  logic [DATA_W-1:0] pwdata_o;
  logic              pready_i;
  logic [DATA_W-1:0] prdata_i;
  logic              pslverr_i;

  int checks = 0;
  int errors = 0;

  cfg_apb_master #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_write_i(req_write_i),
    .req_addr_i (req_addr_i),
    .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o  (rsp_err_o),
    .psel_o     (psel_o),
    .penable_o  (penable_o),
    .paddr_o    (paddr_o),
    .pwrite_o   (pwrite_o),
    .pwdata_o   (pwdata_o),
    .pready_i   (pready_i),
    .prdata_i   (prdata_i),
    .pslverr_i  (pslverr_i)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // Call on a falling edge while the DUT is idle. Returns on the falling
  // edge after the acceptance edge, with req_valid_i dropped.
  task automatic drive_req(input logic wr, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wd);
    req_valid_i = 1'b1;
    req_write_i = wr;
    req_addr_i  = addr;
    req_wdata_i = wd;
    @(negedge clk);
    req_valid_i = 1'b0;
  endtask

  // Accept the pending response, returning one falling edge later.
  task automatic take_rsp();
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (psel_o !== 1'b0) begin errors++; $display("FAIL reset_psel: got %b expected 0", psel_o); end
    checks++; if (penable_o !== 1'b0) begin errors++; $display("FAIL reset_penable: got %b expected 0", penable_o); end
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid_o); end
    checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", req_ready_o); end
    checks++; if (paddr_o !== 12'h000) begin errors++; $display("FAIL reset_paddr: got %h expected 000", paddr_o); end
    checks++; if (rsp_rdata_o !== 32'h0 || rsp_err_o !== 1'b0) begin
      errors++; $display("FAIL reset_rsp: got rdata=%h err=%b expected 0/0", rsp_rdata_o, rsp_err_o);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", req_ready_o); end
  endtask

  task automatic test_read_zero_wait();
    pready_i = 1'b1; pslverr_i = 1'b0; prdata_i = 32'h0001_2024;
    @(negedge clk);
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL rd0_ready: got %b expected 1", req_ready_o); end
    drive_req(1'b0, 12'h000, 32'h0);
    // cycle 1: SETUP
    checks++; if (psel_o !== 1'b1 || penable_o !== 1'b0 || req_ready_o !== 1'b0) begin
      errors++; $display("FAIL rd0_setup: got psel=%b pen=%b rdy=%b expected 1/0/0", psel_o, penable_o, req_ready_o);
    end
    @(negedge clk);
    // cycle 2: ACCESS
    checks++; if (psel_o !== 1'b1 || penable_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
      errors++; $display("FAIL rd0_access: got psel=%b pen=%b vld=%b expected 1/1/0", psel_o, penable_o, rsp_valid_o);
    end
    @(negedge clk);
    // cycle 3: response
    checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h0001_2024 || rsp_err_o !== 1'b0) begin
      errors++; $display("FAIL rd0_rsp: got vld=%b rdata=%h err=%b expected 1/00012024/0", rsp_valid_o, rsp_rdata_o, rsp_err_o);
    end
    checks++; if (psel_o !== 1'b0 || penable_o !== 1'b0) begin
      errors++; $display("FAIL rd0_bus_idle: got psel=%b pen=%b expected 0/0", psel_o, penable_o);
    end
    take_rsp();
    // cycle 4: ready again
    checks++; if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
      errors++; $display("FAIL rd0_after: got vld=%b rdy=%b expected 0/1", rsp_valid_o, req_ready_o);
    end
  endtask

  task automatic test_write_wait();
    int access_cycles;
    access_cycles = 0;
    pready_i = 1'b0; pslverr_i = 1'b0; prdata_i = 32'hDEAD_BEEF;
    drive_req(1'b1, 12'h010, 32'hA5A5_5A5A);
    checks++; if (psel_o !== 1'b1 || penable_o !== 1'b0) begin
      errors++; $display("FAIL wr_setup: got psel=%b pen=%b expected 1/0", psel_o, penable_o);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (penable_o === 1'b1) access_cycles++;
      checks++; if (paddr_o !== 12'h010 || pwdata_o !== 32'hA5A5_5A5A || pwrite_o !== 1'b1 || psel_o !== 1'b1) begin
        errors++; $display("FAIL wr_stable[%0d]: got addr=%h data=%h wr=%b sel=%b expected 010/a5a55a5a/1/1",
                           i, paddr_o, pwdata_o, pwrite_o, psel_o);
      end
      // Three wait states, then ready in the fourth ACCESS cycle.
      pready_i = (i == 3);
    end
    @(negedge clk);
    pready_i = 1'b0;
    checks++; if (access_cycles !== 4) begin errors++; $display("FAIL wr_access_len: got %0d expected 4", access_cycles); end
    checks++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0 || rsp_rdata_o !== 32'h0) begin
      errors++; $display("FAIL wr_rsp: got vld=%b err=%b rdata=%h expected 1/0/00000000", rsp_valid_o, rsp_err_o, rsp_rdata_o);
    end
    take_rsp();
  endtask

  task automatic test_timeout();
    int pen_cycles;
    pen_cycles = 0;
    pready_i = 1'b0; pslverr_i = 1'b0; prdata_i = 32'h1111_1111;
    drive_req(1'b0, 12'h020, 32'h0);
    // now in SETUP; count ACCESS cycles with a hard bound
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (penable_o !== 1'b1) break;
      pen_cycles++;
    end
    checks++; if (pen_cycles !== 16) begin errors++; $display("FAIL to_access_len: got %0d expected 16", pen_cycles); end
    checks++; if (psel_o !== 1'b0 || rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1 || rsp_rdata_o !== 32'h0) begin
      errors++; $display("FAIL to_rsp: got sel=%b vld=%b err=%b rdata=%h expected 0/1/1/00000000",
                         psel_o, rsp_valid_o, rsp_err_o, rsp_rdata_o);
    end
    take_rsp();
    // the next request goes through normally
    pready_i = 1'b1; prdata_i = 32'h0000_0055;
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL to_next_ready: got %b expected 1", req_ready_o); end
    drive_req(1'b0, 12'h004, 32'h0);
    repeat (2) @(negedge clk);
    checks++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0 || rsp_rdata_o !== 32'h0000_0055) begin
      errors++; $display("FAIL to_next_rsp: got vld=%b err=%b rdata=%h expected 1/0/00000055", rsp_valid_o, rsp_err_o, rsp_rdata_o);
    end
    take_rsp();
  endtask

  task automatic test_misaligned();
    pready_i = 1'b1; pslverr_i = 1'b0; prdata_i = 32'hFFFF_FFFF;
    drive_req(1'b0, 12'h002, 32'h0);
    checks++; if (psel_o !== 1'b0 || rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1 || rsp_rdata_o !== 32'h0) begin
      errors++; $display("FAIL mis_rsp: got sel=%b vld=%b err=%b rdata=%h expected 0/1/1/00000000",
                         psel_o, rsp_valid_o, rsp_err_o, rsp_rdata_o);
    end
    checks++; if (paddr_o !== 12'h002) begin errors++; $display("FAIL mis_paddr: got %h expected 002", paddr_o); end
    take_rsp();
    checks++; if (psel_o !== 1'b0 || req_ready_o !== 1'b1) begin
      errors++; $display("FAIL mis_after: got sel=%b rdy=%b expected 0/1", psel_o, req_ready_o);
    end
  endtask

  task automatic test_slverr_hold();
    pready_i = 1'b1; pslverr_i = 1'b1; prdata_i = 32'h1234_5678;
    drive_req(1'b0, 12'h008, 32'h0);
    repeat (2) @(negedge clk);
    // Bus inputs change during RESP and must not disturb the held response.
    pslverr_i = 1'b0; prdata_i = 32'hCAFE_F00D;
    for (int i = 0; i < 5; i++) begin
      checks++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1 || rsp_rdata_o !== 32'h1234_5678) begin
        errors++; $display("FAIL err_hold[%0d]: got vld=%b err=%b rdata=%h expected 1/1/12345678",
                           i, rsp_valid_o, rsp_err_o, rsp_rdata_o);
      end
      @(negedge clk);
    end
    take_rsp();
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL err_release: got %b expected 0", rsp_valid_o); end
  endtask

  task automatic test_reset_mid_access();
    pready_i = 1'b0; pslverr_i = 1'b0; prdata_i = 32'h0;
    drive_req(1'b0, 12'h00C, 32'h0);
    @(negedge clk);
    checks++; if (penable_o !== 1'b1) begin errors++; $display("FAIL rst_pre_access: got %b expected 1", penable_o); end
    #2 rst_n = 1'b0;
    #1;
    // still before the next rising edge
    checks++; if (psel_o !== 1'b0 || penable_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
      errors++; $display("FAIL rst_async: got sel=%b pen=%b vld=%b expected 0/0/0", psel_o, penable_o, rsp_valid_o);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pready_i = 1'b1;
    #1;
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", req_ready_o); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (rsp_valid_o !== 1'b0 || psel_o !== 1'b0) begin
        errors++; $display("FAIL rst_no_rsp[%0d]: got vld=%b sel=%b expected 0/0", i, rsp_valid_o, psel_o);
      end
    end
    prdata_i = 32'h0001_2024;
    drive_req(1'b0, 12'h000, 32'h0);
    repeat (2) @(negedge clk);
    checks++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0 || rsp_rdata_o !== 32'h0001_2024) begin
      errors++; $display("FAIL rst_fresh_rd: got vld=%b err=%b rdata=%h expected 1/0/00012024", rsp_valid_o, rsp_err_o, rsp_rdata_o);
    end
    take_rsp();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    req_valid_i = 1'b0;
    req_write_i = 1'b0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    rsp_ready_i = 1'b0;
    pready_i    = 1'b0;
    prdata_i    = '0;
    pslverr_i   = 1'b0;

    test_reset();
    test_read_zero_wait();
    test_write_wait();
    test_timeout();
    test_misaligned();
    test_slverr_hold();
    test_reset_mid_access();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cfg_apb_master.md
Name: cfg_apb_master

Overview:
- APB3 requester that sits directly upstream of the CC configuration register slave.
- Converts a simple valid/ready register-access request into one APB SETUP→ACCESS transfer.
- Waits for pready, then returns read data and error status on a valid/ready response channel.
- Adds word-alignment checking and a bounded wait-state timeout, so a hung slave cannot stall the config path.

Parameters:
- ADDR_W, 12, APB address width (byte address).
- DATA_W, 32, data width.
- TIMEOUT, 16, maximum ACCESS-phase cycles before the transfer is aborted; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when high with req_valid_i
- req_write_i  in  1  1 = write, 0 = read
- req_addr_i  in  ADDR_W  byte address
- req_wdata_i  in  DATA_W  write data
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed
- rsp_rdata_o  out  DATA_W  read data (0 for writes and errors)
- rsp_err_o  out  1  pslverr, timeout or misaligned address
- psel_o  out  1  APB select
- penable_o  out  1  APB enable
- paddr_o  out  ADDR_W  APB address
- pwrite_o  out  1  APB direction
- pwdata_o  out  DATA_W  APB write data
- pready_i  in  1  APB ready
- prdata_i  in  DATA_W  APB read data
- pslverr_i  in  1  APB slave error

Behaviour:
- Reset (async, rst_n=0): state=IDLE and all outputs 0. Exception: req_ready_o=1 once rst_n is high. Internal wait counter=0.
- States: IDLE, SETUP, ACCESS, RESP. All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i & req_ready_o: latch write, addr and wdata into paddr_o/pwrite_o/pwdata_o.
  - If req_addr_i[1:0]==0, go to SETUP.
  - Otherwise go directly to RESP with rsp_err_o=1 and rsp_rdata_o=0; no APB activity.
- SETUP: psel_o=1, penable_o=0 for exactly 1 cycle, then ACCESS. req_ready_o=0.
- ACCESS:
  - psel_o=1, penable_o=1. paddr/pwrite/pwdata are held stable from SETUP through the last ACCESS cycle.
  - On pready_i=1: capture rsp_rdata_o = pwrite_o ? 0 : prdata_i, and rsp_err_o = pslverr_i; go to RESP.
  - Each ACCESS cycle with pready_i=0 increments the wait counter.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT-1 with pready_i still 0: abort, go to RESP with rsp_err_o=1 and rsp_rdata_o=0.
  - ACCESS therefore lasts at most TIMEOUT cycles. The counter clears on leaving ACCESS.
  - pready_i=1 in the final (timeout) cycle counts as a normal completion.
- RESP:
  - psel_o=penable_o=0, rsp_valid_o=1; rsp_rdata_o and rsp_err_o are held until rsp_ready_i.
  - On rsp_valid_o & rsp_ready_i, go to IDLE next cycle.
  - rsp_valid_o is never withdrawn without a handshake.
- Latency:
  - Zero-wait-state read: request accepted at cycle 0, SETUP at 1, ACCESS at 2, rsp_valid_o at 3.
  - Next request can be accepted at cycle 4 at the earliest when rsp_ready_i=1 at cycle 3.
- One transfer is outstanding at most; no pipelining or back-to-back APB transfers.
- APB outputs paddr/pwrite/pwdata keep their last values in IDLE and RESP; psel_o=0 there.
- Reset mid-operation: the in-flight transfer is dropped silently. psel/penable/rsp_valid fall to 0 asynchronously and no response is generated.
- pslverr_i and prdata_i are ignored except in an ACCESS cycle with pready_i=1.

Test Plan:
1. Read addr 0x000 against the config slave model (pready=1, version reg 0x0001_2024):
   - psel=1/penable=0 for 1 cycle, then penable=1 for 1 cycle.
   - rsp_valid 3 cycles after acceptance with rdata=0x0001_2024, err=0.
2. Write addr 0x010, data 0xA5A5_5A5A, with pready held low 3 ACCESS cycles:
   - ACCESS lasts 4 cycles; paddr/pwdata/pwrite stable throughout.
   - Response err=0, rdata=0.
3. TIMEOUT=16, pready stuck at 0 on a read:
   - penable high exactly 16 cycles, then psel/penable drop.
   - Response err=1, rdata=0; the next request is accepted normally.
4. Misaligned read addr 0x002:
   - psel never asserts.
   - rsp_valid the cycle after acceptance with err=1, rdata=0.
5. Read completes with pready=1, pslverr=1, prdata=0x1234_5678:
   - Response err=1, rdata=0x1234_5678.
   - With rsp_ready held 0 for 5 cycles, rsp_valid and data stay stable.
6. rst_n pulled low during ACCESS:
   - psel/penable/rsp_valid go 0 without waiting for clk.
   - No response is issued; after release req_ready=1 and a fresh read of 0x000 completes correctly.
